// File: rtl/regfile_pkg.sv
// regfile_pkg: shared sizes and types for the register file
package regfile_pkg;
    localparam int DATA_WIDTH = 64;
    localparam int NUM_REGS   = 32;
    localparam int ADDR_WIDTH = $clog2(NUM_REGS);
    localparam int ZERO_REG   = 31;
    typedef logic [ADDR_WIDTH-1:0] reg_addr_t;
    typedef logic [DATA_WIDTH-1:0] word_t;
endpackage

// File: rtl/regfile_decoder.sv
// regfile_decoder: write-address decoder producing per-register write enables
//   en   - write enable (RegWrite)
//   addr - destination register index
//   we   - one-hot write enables; the zero register's bit is never set
module regfile_decoder
    import regfile_pkg::*;
(
    input  logic                en,
    input  reg_addr_t           addr,
    output logic [NUM_REGS-1:0] we
);
    always_comb begin
        we = '0;
        if (en)
            we[addr] = 1'b1;
        we[ZERO_REG] = 1'b0;
    end
endmodule

// File: rtl/regfile.sv
// regfile: 32 x 64-bit register file, two combinational reads, one write, with bypass
//   clk           - clock, writes on rising edge
//   reset         - asynchronous active-high clear of all registers
//   RegWrite      - write enable
//   WriteRegister - write index
//   WriteData     - write data
//   ReadRegister1 - read index, port 1 (ALU A)
//   ReadRegister2 - read index, port 2 (ALU B)
//   ReadData1     - read data, port 1
//   ReadData2     - read data, port 2
module regfile
    import regfile_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      RegWrite,
    input  reg_addr_t WriteRegister,
    input  word_t     WriteData,
    input  reg_addr_t ReadRegister1,
    input  reg_addr_t ReadRegister2,
    output word_t     ReadData1,
    output word_t     ReadData2
);
    logic [NUM_REGS-1:0] we;
    word_t               mem [NUM_REGS];
    logic                byp1, byp2;

    regfile_decoder u_dec (
        .en   (RegWrite),
        .addr (WriteRegister),
        .we   (we)
    );

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        if (i == ZERO_REG) begin : g_zero
            assign mem[i] = '0;
        end else begin : g_store
            always_ff @(posedge clk or posedge reset) begin
                if (reset)
                    mem[i] <= '0;
                else if (we[i])
                    mem[i] <= WriteData;
            end
        end
    end

    // Forwarding is suppressed during reset so every read is zero while reset is held.
    assign byp1 = !reset && RegWrite && WriteRegister == ReadRegister1 && WriteRegister != reg_addr_t'(ZERO_REG);
    assign byp2 = !reset && RegWrite && WriteRegister == ReadRegister2 && WriteRegister != reg_addr_t'(ZERO_REG);

    assign ReadData1 = (reset || ReadRegister1 == reg_addr_t'(ZERO_REG)) ? '0 : byp1 ? WriteData : mem[ReadRegister1];
    assign ReadData2 = (reset || ReadRegister2 == reg_addr_t'(ZERO_REG)) ? '0 : byp2 ? WriteData : mem[ReadRegister2];
endmodule

// File: tb/tb_regfile.sv
// tb_regfile: directed and random self-checking bench for regfile
module tb_regfile;
    logic        clk = 1'b0;
    logic        reset;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [63:0] WriteData;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic [63:0] ReadData1;
    logic [63:0] ReadData2;

    int n_cmp = 0;
    int n_fail = 0;
    logic [63:0] mdl [32];

    regfile dut (
        .clk           (clk),
        .reset         (reset),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .ReadData1     (ReadData1),
        .ReadData2     (ReadData2)
    );

    always #5 clk = ~clk;

    task automatic write_reg(input logic [4:0] a, input logic [63:0] d);
        @(negedge clk);
        RegWrite = 1'b1;
        WriteRegister = a;
        WriteData = d;
        @(posedge clk);
        if (a != 5'd31)
            mdl[a] = d;
        #1 RegWrite = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        RegWrite = 1'b1;
        WriteRegister = 5'd4;
        WriteData = 64'hFFFF_0000_FFFF_0000;
        for (int i = 0; i < 32; i++) begin
            ReadRegister1 = 5'(i);
            ReadRegister2 = 5'(31 - i);
            #1;
            n_cmp++;
            if (ReadData1 !== 64'h0) begin
                n_fail++;
                $display("FAIL reset_rd1[%0d]: got %h want 0", i, ReadData1);
            end
            n_cmp++;
            if (ReadData2 !== 64'h0) begin
                n_fail++;
                $display("FAIL reset_rd2[%0d]: got %h want 0", 31 - i, ReadData2);
            end
        end
        @(posedge clk);
        #1;
        RegWrite = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        for (int i = 0; i < 32; i++) mdl[i] = 64'h0;
        @(negedge clk);
        for (int i = 0; i < 32; i++) begin
            ReadRegister1 = 5'(i);
            ReadRegister2 = 5'(i);
            #0.1;
            n_cmp++;
            if (ReadData1 !== 64'h0 || ReadData2 !== 64'h0) begin
                n_fail++;
                $display("FAIL post_reset[%0d]: got %h/%h want 0/0", i, ReadData1, ReadData2);
            end
        end
    endtask

    task automatic test_basic;
        write_reg(5'd3, 64'hFFFF_FFFF_FFFF_FFFD);
        write_reg(5'd7, 64'h0000_0000_0000_000B);
        @(negedge clk);
        ReadRegister1 = 5'd3;
        ReadRegister2 = 5'd7;
        #1;
        n_cmp++;
        if (ReadData1 !== 64'hFFFF_FFFF_FFFF_FFFD) begin
            n_fail++;
            $display("FAIL basic_rd1: got %h want fffffffffffffffd", ReadData1);
        end
        n_cmp++;
        if (ReadData2 !== 64'hB) begin
            n_fail++;
            $display("FAIL basic_rd2: got %h want 000000000000000b", ReadData2);
        end
    endtask

    task automatic test_zero_reg;
        @(negedge clk);
        RegWrite = 1'b1;
        WriteRegister = 5'd31;
        WriteData = 64'hDEAD_BEEF_DEAD_BEEF;
        ReadRegister1 = 5'd31;
        ReadRegister2 = 5'd31;
        #1;
        n_cmp++;
        if (ReadData1 !== 64'h0 || ReadData2 !== 64'h0) begin
            n_fail++;
            $display("FAIL zero_same_cycle: got %h/%h want 0/0", ReadData1, ReadData2);
        end
        @(posedge clk);
        #1 RegWrite = 1'b0;
        #1;
        n_cmp++;
        if (ReadData1 !== 64'h0 || ReadData2 !== 64'h0) begin
            n_fail++;
            $display("FAIL zero_next_cycle: got %h/%h want 0/0", ReadData1, ReadData2);
        end
    endtask

    task automatic test_bypass;
        @(negedge clk);
        RegWrite = 1'b1;
        WriteRegister = 5'd5;
        WriteData = 64'h1234_5678_9ABC_DEF0;
        ReadRegister1 = 5'd5;
        ReadRegister2 = 5'd5;
        #1;
        n_cmp++;
        if (ReadData1 !== 64'h1234_5678_9ABC_DEF0 || ReadData2 !== 64'h1234_5678_9ABC_DEF0) begin
            n_fail++;
            $display("FAIL bypass_both: got %h/%h want 123456789abcdef0", ReadData1, ReadData2);
        end
        ReadRegister2 = 5'd3;
        #1;
        n_cmp++;
        if (ReadData1 !== 64'h1234_5678_9ABC_DEF0 || ReadData2 !== 64'hFFFF_FFFF_FFFF_FFFD) begin
            n_fail++;
            $display("FAIL bypass_one_port: got %h/%h want 123456789abcdef0/fffffffffffffffd", ReadData1, ReadData2);
        end
        @(posedge clk);
        mdl[5] = 64'h1234_5678_9ABC_DEF0;
        #1 RegWrite = 1'b0;
        ReadRegister2 = 5'd5;
        #1;
        n_cmp++;
        if (ReadData1 !== 64'h1234_5678_9ABC_DEF0 || ReadData2 !== 64'h1234_5678_9ABC_DEF0) begin
            n_fail++;
            $display("FAIL bypass_stored: got %h/%h want 123456789abcdef0", ReadData1, ReadData2);
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        RegWrite = 1'b1;
        WriteRegister = 5'd9;
        WriteData = 64'hAAAA;
        ReadRegister1 = 5'd9;
        ReadRegister2 = 5'd9;
        @(posedge clk);
        #1 WriteData = 64'hBBBB;
        RegWrite = 1'b0;
        #1;
        n_cmp++;
        if (ReadData1 !== 64'hAAAA) begin
            n_fail++;
            $display("FAIL b2b_first: got %h want aaaa", ReadData1);
        end
        RegWrite = 1'b1;
        @(posedge clk);
        #1 RegWrite = 1'b0;
        #1;
        mdl[9] = 64'hBBBB;
        n_cmp++;
        if (ReadData1 !== 64'hBBBB || ReadData2 !== 64'hBBBB) begin
            n_fail++;
            $display("FAIL b2b_last: got %h/%h want bbbb", ReadData1, ReadData2);
        end
    endtask

    task automatic test_no_write;
        write_reg(5'd0, 64'h0123_4567_89AB_CDEF);
        @(negedge clk);
        RegWrite = 1'b0;
        WriteRegister = 5'bx;
        WriteData = 64'hFFFF_FFFF_FFFF_FFFF;
        repeat (2) @(posedge clk);
        #1;
        ReadRegister1 = 5'd0;
        ReadRegister2 = 5'd3;
        #1;
        n_cmp++;
        if (ReadData1 !== 64'h0123_4567_89AB_CDEF || ReadData2 !== 64'hFFFF_FFFF_FFFF_FFFD) begin
            n_fail++;
            $display("FAIL no_write: got %h/%h want 0123456789abcdef/fffffffffffffffd", ReadData1, ReadData2);
        end
    endtask

    task automatic test_async_reset;
        write_reg(5'd10, 64'hA5A5_A5A5_A5A5_A5A5);
        @(negedge clk);
        ReadRegister1 = 5'd10;
        ReadRegister2 = 5'd7;
        #1;
        n_cmp++;
        if (ReadData1 !== 64'hA5A5_A5A5_A5A5_A5A5) begin
            n_fail++;
            $display("FAIL async_preload: got %h want a5a5a5a5a5a5a5a5", ReadData1);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if (ReadData1 !== 64'h0 || ReadData2 !== 64'h0) begin
            n_fail++;
            $display("FAIL async_reset_during: got %h/%h want 0/0", ReadData1, ReadData2);
        end
        reset = 1'b0;
        for (int i = 0; i < 32; i++) mdl[i] = 64'h0;
        #1;
        n_cmp++;
        if (ReadData1 !== 64'h0 || ReadData2 !== 64'h0) begin
            n_fail++;
            $display("FAIL async_reset_after: got %h/%h want 0/0", ReadData1, ReadData2);
        end
    endtask

    task automatic test_random;
        logic [63:0] e1, e2;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            RegWrite = 1'($urandom_range(0, 1));
            WriteRegister = 5'($urandom_range(0, 31));
            WriteData = {$urandom, $urandom};
            ReadRegister1 = ($urandom_range(0, 3) == 0) ? WriteRegister : 5'($urandom_range(0, 31));
            ReadRegister2 = ($urandom_range(0, 3) == 0) ? WriteRegister : 5'($urandom_range(0, 31));
            #1;
            e1 = (ReadRegister1 == 5'd31) ? 64'h0 : (RegWrite && WriteRegister == ReadRegister1) ? WriteData : mdl[ReadRegister1];
            e2 = (ReadRegister2 == 5'd31) ? 64'h0 : (RegWrite && WriteRegister == ReadRegister2) ? WriteData : mdl[ReadRegister2];
            n_cmp++;
            if (ReadData1 !== e1 || ReadData2 !== e2) begin
                n_fail++;
                $display("FAIL random[%0d]: got %h/%h want %h/%h", n, ReadData1, ReadData2, e1, e2);
            end
            if (RegWrite && WriteRegister != 5'd31)
                mdl[WriteRegister] = WriteData;
        end
        @(negedge clk);
        RegWrite = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_reg();
        test_bypass();
        test_back_to_back();
        test_no_write();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
